// File: rtl/serial_twos_comp.sv
// Bit-serial pass/negate of LSB-first W-bit words, with overflow and framing-error flags.
// Define SER_TC_ABS_EN for the store-and-forward build: absolute-value mode and input back-pressure.
module serial_twos_comp #(
    parameter int unsigned W = 8
) (
    input  logic       t_clk,
    input  logic       r,
    input  logic       i_valid,
    output logic       i_rdy,
    input  logic       i,
    input  logic       i_sow,
    input  logic [1:0] mode,
    output logic       y,
    output logic       o_valid,
    output logic       o_sow,
    output logic       o_eow,
    output logic       ovf,
    output logic       frm_err
);

    localparam int unsigned   CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic          seen_q, seen_d;
    logic          neg_q, neg_d;
    logic          y_q, y_d;
    logic          o_valid_q, o_valid_d;
    logic          o_sow_q, o_sow_d;
    logic          o_eow_q, o_eow_d;
    logic          ovf_q, ovf_d;
    logic          frm_err_q, frm_err_d;
    logic          accept;

    assign cnt_nxt = cnt_q + CW'(1);

`ifdef SER_TC_ABS_EN
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [1:0]    mode_q, mode_d;
    logic [W-1:0]  word_full;

    assign i_rdy     = (state_q != EMIT);
    assign accept    = i_valid & i_rdy;
    // Buffer fills from the top, so bit 0 reaches buf_q[0] once all W beats are in.
    assign word_full = {i, buf_q[W-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        neg_d     = neg_q;
        buf_d     = buf_q;
        mode_d    = mode_q;
        y_d       = 1'b0;
        o_valid_d = 1'b0;
        o_sow_d   = 1'b0;
        o_eow_d   = 1'b0;
        ovf_d     = 1'b0;
        frm_err_d = 1'b0;
        if (state_q == EMIT) begin
            y_d       = (neg_q & seen_q) ? ~buf_q[0] : buf_q[0];
            seen_d    = seen_q | buf_q[0];
            buf_d     = buf_q >> 1;
            o_valid_d = 1'b1;
            o_sow_d   = (cnt_q == '0);
            if (cnt_q == LAST) begin
                o_eow_d = 1'b1;
                ovf_d   = neg_q & ~seen_q & buf_q[0];
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_nxt;
            end
        end else if (accept) begin
            if (i_sow) begin
                frm_err_d = (state_q == LOAD);
                mode_d    = mode;
                cnt_d     = '0;
                buf_d     = word_full;
                state_d   = LOAD;
            end else if (state_q == IDLE) begin
                frm_err_d = 1'b1;
            end else begin
                buf_d = word_full;
                if (cnt_nxt == LAST) begin
                    // The incoming beat is the MSB, which decides negation in absolute mode.
                    neg_d   = (mode_q == 2'b10) ? i : mode_q[0];
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
        end
    end

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            buf_q  <= '0;
            mode_q <= '0;
        end else begin
            buf_q  <= buf_d;
            mode_q <= mode_d;
        end
    end
`else
    typedef enum logic [0:0] {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    assign i_rdy  = 1'b1;
    assign accept = i_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        neg_d     = neg_q;
        y_d       = 1'b0;
        o_valid_d = 1'b0;
        o_sow_d   = 1'b0;
        o_eow_d   = 1'b0;
        ovf_d     = 1'b0;
        frm_err_d = 1'b0;
        if (accept) begin
            if (i_sow) begin
                frm_err_d = (state_q == ACTIVE);
                neg_d     = (mode == 2'b01) || (mode == 2'b11);
                cnt_d     = '0;
                seen_d    = i;
                y_d       = i;
                o_valid_d = 1'b1;
                o_sow_d   = 1'b1;
                state_d   = ACTIVE;
            end else if (state_q == IDLE) begin
                frm_err_d = 1'b1;
            end else begin
                y_d       = (neg_q & seen_q) ? ~i : i;
                seen_d    = seen_q | i;
                o_valid_d = 1'b1;
                if (cnt_nxt == LAST) begin
                    o_eow_d = 1'b1;
                    ovf_d   = neg_q & ~seen_q & i;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
        end
    end
`endif

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
            neg_q     <= 1'b0;
            y_q       <= 1'b0;
            o_valid_q <= 1'b0;
            o_sow_q   <= 1'b0;
            o_eow_q   <= 1'b0;
            ovf_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            neg_q     <= neg_d;
            y_q       <= y_d;
            o_valid_q <= o_valid_d;
            o_sow_q   <= o_sow_d;
            o_eow_q   <= o_eow_d;
            ovf_q     <= ovf_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign y       = y_q;
    assign o_valid = o_valid_q;
    assign o_sow   = o_sow_q;
    assign o_eow   = o_eow_q;
    assign ovf     = ovf_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Self-checking bench for serial_twos_comp; follows SER_TC_ABS_EN to select the expected build behaviour.
module tb_serial_twos_comp;

    localparam int unsigned W = 8;

    logic       t_clk = 1'b0;
    logic       r;
    logic       i_valid;
    logic       i_rdy;
    logic       i;
    logic       i_sow;
    logic [1:0] mode;
    logic       y;
    logic       o_valid;
    logic       o_sow;
    logic       o_eow;
    logic       ovf;
    logic       frm_err;

    int checks   = 0;
    int failures = 0;

    always #5 t_clk = ~t_clk;

    serial_twos_comp #(.W(W)) dut (
        .t_clk  (t_clk),
        .r      (r),
        .i_valid(i_valid),
        .i_rdy  (i_rdy),
        .i      (i),
        .i_sow  (i_sow),
        .mode   (mode),
        .y      (y),
        .o_valid(o_valid),
        .o_sow  (o_sow),
        .o_eow  (o_eow),
        .ovf    (ovf),
        .frm_err(frm_err)
    );

    // Observed/expected vector: {i_rdy, o_valid, y (when valid), o_sow, o_eow, ovf, frm_err}
    typedef struct packed {
        logic       v;
        logic       sow;
        logic       b;
        logic [1:0] m;
        logic [6:0] exp;
    } beat_t;

    beat_t q[$];

    function automatic logic [6:0] ex(input logic rdy, input logic v, input logic yb, input logic s,
                                      input logic e, input logic o, input logic f);
        return {rdy, v, yb, s, e, o, f};
    endfunction

    function automatic beat_t mk(input logic v, input logic sow, input logic b, input logic [1:0] m,
                                 input logic [6:0] e);
        beat_t t;
        t.v = v; t.sow = sow; t.b = b; t.m = m; t.exp = e;
        return t;
    endfunction

    function automatic beat_t mk_idle();
        return mk(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), ex(1, 0, 0, 0, 0, 0, 0));
    endfunction

    // Word-level reference: returns {ovf, result}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [1:0] m);
        logic         neg;
        logic [W-1:0] res;
`ifdef SER_TC_ABS_EN
        neg = (m == 2'b10) ? x[W-1] : m[0];
`else
        neg = m[0];
`endif
        res = neg ? (W'(0) - x) : x;
        return {neg && (x == (W'(1) << (W - 1))), res};
    endfunction

    // Queue the beats of one word together with the outputs expected after each cycle.
    task automatic add_word(input logic [W-1:0] x, input logic [1:0] m, input logic [W-1:0] res,
                            input logic ov, input bit gaps);
        for (int unsigned j = 0; j < W; j++) begin
            if (gaps && j != 0) repeat ($urandom_range(0, 2)) q.push_back(mk_idle());
`ifdef SER_TC_ABS_EN
            q.push_back(mk(1'b1, j == 0, x[j], (j == 0) ? m : 2'($urandom), ex(j != W - 1, 0, 0, 0, 0, 0, 0)));
`else
            q.push_back(mk(1'b1, j == 0, x[j], (j == 0) ? m : 2'($urandom),
                           ex(1, 1, res[j], j == 0, j == W - 1, ov && (j == W - 1), 0)));
`endif
        end
`ifdef SER_TC_ABS_EN
        for (int unsigned k = 0; k < W; k++)
            q.push_back(mk(1'b1, 1'($urandom), 1'($urandom), 2'($urandom),
                           ex(k == W - 1, 1, res[k], k == 0, k == W - 1, ov && (k == W - 1), 0)));
`endif
    endtask

    // Called at a falling edge: drive one cycle of inputs, return outputs at the next falling edge.
    task automatic step(input beat_t b, output logic [6:0] obs);
        i_valid = b.v;
        i_sow   = b.sow;
        i       = b.b;
        mode    = b.m;
        @(negedge t_clk);
        obs = {i_rdy, o_valid, o_valid & y, o_sow, o_eow, ovf, frm_err};
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        r = 1'b0; i_valid = 1'b1; i_sow = 1'b1; i = 1'b1; mode = 2'b01;
        repeat (2) @(negedge t_clk);
        obs = {i_rdy, o_valid, y, o_sow, o_eow, ovf, frm_err};
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 0));
        end
        r = 1'b1;
        step(mk(1'b1, 1'b0, 1'b1, 2'b00, '0), obs);
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 1)) begin
            failures++;
            $display("FAIL reset_first_no_sow got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 1));
        end
        step(mk_idle(), obs);
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL frm_err_pulse_width got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_directed();
        beat_t      b;
        logic [6:0] obs;
        int         n = 0;
        add_word(8'h5A, 2'b00, 8'h5A, 1'b0, 0);
        add_word(8'h05, 2'b01, 8'hFB, 1'b0, 0);
        add_word(8'h80, 2'b01, 8'h80, 1'b1, 0);
        add_word(8'h00, 2'b11, 8'h00, 1'b0, 0);
`ifdef SER_TC_ABS_EN
        add_word(8'hFB, 2'b10, 8'h05, 1'b0, 0);
        add_word(8'h05, 2'b10, 8'h05, 1'b0, 0);
        add_word(8'h80, 2'b10, 8'h80, 1'b1, 0);
`else
        add_word(8'h80, 2'b10, 8'h80, 1'b0, 0);
`endif
        q.push_back(mk_idle());
        while (q.size() > 0) begin
            b = q.pop_front();
            step(b, obs);
            checks++;
            if (obs !== b.exp) begin
                failures++;
                $display("FAIL directed beat=%0d got=%b exp=%b", n, obs, b.exp);
            end
            n++;
        end
    endtask

    task automatic test_gap_frm();
        beat_t        b;
        logic [6:0]   obs;
        logic [W-1:0] xa, xb;
        logic [W:0]   ra, rb;
        int           idx;
        int           n = 0;
        xa = W'($urandom); xb = W'($urandom);
        ra = model(xa, 2'b01); rb = model(xb, 2'b01);
        for (int unsigned j = 0; j < 4; j++) begin
            if (j == 3) repeat (3) q.push_back(mk_idle());
`ifdef SER_TC_ABS_EN
            q.push_back(mk(1'b1, j == 0, xa[j], 2'b01, ex(1, 0, 0, 0, 0, 0, 0)));
`else
            q.push_back(mk(1'b1, j == 0, xa[j], 2'b01, ex(1, 1, ra[j], j == 0, 0, 0, 0)));
`endif
        end
        idx = q.size();
        add_word(xb, 2'b01, rb[W-1:0], rb[W], 0);
        b = q[idx];
        b.exp[0] = 1'b1;
        q[idx] = b;
        q.push_back(mk_idle());
        while (q.size() > 0) begin
            b = q.pop_front();
            step(b, obs);
            checks++;
            if (obs !== b.exp) begin
                failures++;
                $display("FAIL gap_frm beat=%0d got=%b exp=%b", n, obs, b.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        beat_t        b;
        logic [6:0]   obs;
        logic [W-1:0] x;
        logic [W:0]   rr;
        int           k;
        x  = W'($urandom) | W'(1);
        rr = model(x, 2'b01);
        add_word(x, 2'b01, rr[W-1:0], rr[W], 0);
`ifdef SER_TC_ABS_EN
        k = W + 3;
`else
        k = 5;
`endif
        for (int n = 0; n < k; n++) begin
            b = q.pop_front();
            step(b, obs);
            checks++;
            if (obs !== b.exp) begin
                failures++;
                $display("FAIL reset_mid_pre beat=%0d got=%b exp=%b", n, obs, b.exp);
            end
        end
        b = q[0];
        i_valid = b.v; i_sow = b.sow; i = b.b; mode = b.m;
        #2 r = 1'b0;
        #1;
        obs = {i_rdy, o_valid, y, o_sow, o_eow, ovf, frm_err};
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 0));
        end
        q.delete();
        @(negedge t_clk);
        r = 1'b1;
        step(mk(1'b1, 1'b0, 1'b1, 2'b01, '0), obs);
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 1)) begin
            failures++;
            $display("FAIL reset_mid_no_sow got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 1));
        end
        step(mk_idle(), obs);
        checks++;
        if (obs !== ex(1, 0, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_mid_idle got=%b exp=%b", obs, ex(1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_random(input int unsigned nwords);
        beat_t        b;
        logic [6:0]   obs;
        logic [W-1:0] x;
        logic [1:0]   m;
        logic [W:0]   rr;
        int           n = 0;
        for (int unsigned w = 0; w < nwords; w++) begin
            case ($urandom_range(0, 5))
                0:       x = W'(1) << (W - 1);
                1:       x = '0;
                default: x = W'($urandom);
            endcase
            m  = 2'($urandom);
            rr = model(x, m);
            add_word(x, m, rr[W-1:0], rr[W], 1);
            if ($urandom_range(0, 3) == 0) q.push_back(mk_idle());
        end
        q.push_back(mk_idle());
        while (q.size() > 0) begin
            b = q.pop_front();
            step(b, obs);
            checks++;
            if (obs !== b.exp) begin
                failures++;
                $display("FAIL random beat=%0d got=%b exp=%b", n, obs, b.exp);
            end
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_gap_frm();
        test_reset_mid();
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
